// File: rtl/adc_axis_packetizer.sv
// ADC sample packetizer: buffers a 32-bit sample stream and emits fixed-length AXI4-Stream packets.
// Optional input stall counter on port stall_count, enabled by defining ADC_PKT_STALL_CNT_EN.
module adc_axis_packetizer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned LEN_WIDTH  = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  enable,
   input  logic [LEN_WIDTH-1:0]  pkt_len,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [31:0]           pkt_count,
   output logic                  busy
`ifdef ADC_PKT_STALL_CNT_EN
   ,
   output logic [15:0]           stall_count
`endif
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned EW = DATA_WIDTH + 1;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   logic [1:0]           rst_sync_q;
   logic                 run_ok;
   logic [0:0]           state_q, state_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic [LEN_WIDTH-1:0] len_sel;
   logic                 beat_last;
   logic                 push, pop;
   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic                 fifo_full, fifo_empty;
   logic [EW-1:0]        mem [FIFO_DEPTH];
   logic [EW-1:0]        head;

   // Reset release synchroniser; the FSM may only start once this has filled
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) rst_sync_q <= '0;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign run_ok = rst_sync_q[1];

   assign len_sel   = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
   assign beat_last = (cnt_q == (len_q - LEN_WIDTH'(1)));

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign busy          = (state_q == ST_ACTIVE);
   assign s_axis_tready = (state_q == ST_ACTIVE) && !fifo_full;
   assign push          = s_axis_tvalid && s_axis_tready;

   assign head          = mem[rd_ptr[AW-1:0]];
   assign m_axis_tdata  = head[DATA_WIDTH-1:0];
   assign m_axis_tlast  = head[DATA_WIDTH];
   assign m_axis_tvalid = !fifo_empty;
   assign pop           = m_axis_tvalid && m_axis_tready;

   // FSM state register
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         len_q   <= LEN_WIDTH'(1);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

   // Next state: enable and pkt_len only take effect at packet boundaries
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (enable && run_ok) begin
               state_d = ST_ACTIVE;
               len_d   = len_sel;
            end
         end
         ST_ACTIVE: begin
            if (push) begin
               if (beat_last) begin
                  cnt_d = '0;
                  if (enable) len_d   = len_sel;
                  else        state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + LEN_WIDTH'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FIFO storage and pointers; entries are {last, data}
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= {beat_last, s_axis_tdata};
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)                pkt_count <= '0;
      else if (pop && m_axis_tlast) pkt_count <= pkt_count + 32'd1;
   end

`ifdef ADC_PKT_STALL_CNT_EN
   // Saturating count of cycles the converter had to hold a sample
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)
         stall_count <= '0;
      else if (s_axis_tvalid && !s_axis_tready && (stall_count != 16'hFFFF))
         stall_count <= stall_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_adc_axis_packetizer.sv
// Directed self-checking bench for adc_axis_packetizer (stall_count checks follow ADC_PKT_STALL_CNT_EN).
module tb_adc_axis_packetizer;

   logic        ACLK;
   logic        ARESETN;
   logic        enable;
   logic [15:0] pkt_len;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic [31:0] pkt_count;
   logic        busy;
`ifdef ADC_PKT_STALL_CNT_EN
   logic [15:0] stall_count;
`endif

   int   tests = 0;
   int   fails = 0;
   int   acc;
   logic tr;

   adc_axis_packetizer #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .LEN_WIDTH(16)) dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .enable        (enable),
      .pkt_len       (pkt_len),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .pkt_count     (pkt_count),
      .busy          (busy)
`ifdef ADC_PKT_STALL_CNT_EN
      ,
      .stall_count   (stall_count)
`endif
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge ACLK);
      #1;
   endtask

   // One accepted beat with the output draining; the new beat must be at the head
   task automatic push_beat(input logic [31:0] d, input logic last, input string tag);
      chk({tag, "_rdy"}, 32'(s_axis_tready), 32'd1);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      cyc();
      s_axis_tvalid = 1'b0;
      chk({tag, "_vld"},  32'(m_axis_tvalid), 32'd1);
      chk({tag, "_data"}, m_axis_tdata, d);
      chk({tag, "_last"}, 32'(m_axis_tlast), 32'(last));
   endtask

   task automatic wait_busy(input string tag);
      int n;
      n = 0;
      while (!busy && n < 8) begin
         cyc();
         n++;
      end
      chk(tag, 32'(busy), 32'd1);
   endtask

   initial begin
      ARESETN       = 1'b0;
      enable        = 1'b1;
      pkt_len       = 16'd4;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      #1;
      chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
      chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_m_tlast",  32'(m_axis_tlast),  32'd0);
      chk("rst_m_tdata",  m_axis_tdata,       32'd0);
      chk("rst_pkt_count", pkt_count,         32'd0);
      chk("rst_busy",     32'(busy),          32'd0);
`ifdef ADC_PKT_STALL_CNT_EN
      chk("rst_stall",    32'(stall_count),   32'd0);
`endif
      repeat (2) cyc();
      ARESETN = 1'b1;
      cyc();
      chk("sync_busy_e1", 32'(busy), 32'd0);
      wait_busy("sync_busy");

      // Basic: two 4-beat packets back-to-back
      for (int i = 1; i <= 8; i++) begin
         push_beat(32'(i), (i % 4) == 0, "t1");
         chk("t1_pkt_count", pkt_count, 32'((i - 1) / 4));
      end
      cyc();
      chk("t1_pkt_count_end", pkt_count, 32'd2);
      chk("t1_empty", 32'(m_axis_tvalid), 32'd0);

      // Backpressure: 20 offered, 16 fit
      m_axis_tready = 1'b0;
      acc = 0;
      s_axis_tvalid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tr = s_axis_tready;
         s_axis_tdata = 32'(100 + acc);
         cyc();
         if (tr) acc++;
      end
      s_axis_tvalid = 1'b0;
      chk("t2_accepted", 32'(acc), 32'd16);
      chk("t2_full_rdy", 32'(s_axis_tready), 32'd0);
      chk("t2_hold_vld", 32'(m_axis_tvalid), 32'd1);
      chk("t2_hold_data", m_axis_tdata, 32'd100);
`ifdef ADC_PKT_STALL_CNT_EN
      chk("t2_stall", 32'(stall_count), 32'd4);
`endif
      m_axis_tready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         chk("t2_out_vld",  32'(m_axis_tvalid), 32'd1);
         chk("t2_out_data", m_axis_tdata, 32'(100 + k));
         chk("t2_out_last", 32'(m_axis_tlast), 32'((k % 4) == 3));
         cyc();
      end
      chk("t2_drained", 32'(m_axis_tvalid), 32'd0);
      chk("t2_pkt_count", pkt_count, 32'd6);
      chk("t2_rdy_back", 32'(s_axis_tready), 32'd1);

      // Enable low at a boundary finishes the current 4-beat packet, then idles
      enable = 1'b0;
      for (int i = 0; i < 4; i++) push_beat(32'(200 + i), i == 3, "t3a");
      chk("t3a_busy", 32'(busy), 32'd0);
      chk("t3a_rdy",  32'(s_axis_tready), 32'd0);
      pkt_len = 16'd8;
      enable  = 1'b1;
      cyc();
      chk("t3_start_rdy",  32'(s_axis_tready), 32'd1);
      chk("t3_start_busy", 32'(busy), 32'd1);
      chk("t3_pkt_count",  pkt_count, 32'd7);
      // Enable drops after beat 3; the 8-beat packet still completes
      for (int i = 1; i <= 8; i++) begin
         push_beat(32'(300 + i), i == 8, "t3");
         if (i == 3) enable = 1'b0;
      end
      chk("t3_end_busy", 32'(busy), 32'd0);
      chk("t3_end_rdy",  32'(s_axis_tready), 32'd0);

      // pkt_len = 0 acts as 1, then a mid-packet change is ignored
      pkt_len = 16'd0;
      enable  = 1'b1;
      cyc();
      chk("t4_pkt_count_start", pkt_count, 32'd8);
      push_beat(32'd401, 1'b1, "t4_len0a");
      push_beat(32'd402, 1'b1, "t4_len0b");
      pkt_len = 16'd4;
      push_beat(32'd403, 1'b1, "t4_len0c");
      push_beat(32'd404, 1'b0, "t4_p4b1");
      pkt_len = 16'd2;
      push_beat(32'd405, 1'b0, "t4_p4b2");
      push_beat(32'd406, 1'b0, "t4_p4b3");
      push_beat(32'd407, 1'b1, "t4_p4b4");
      push_beat(32'd408, 1'b0, "t4_p2b1");
      enable = 1'b0;
      push_beat(32'd409, 1'b1, "t4_p2b2");
      cyc();
      chk("t4_pkt_count", pkt_count, 32'd13);
      chk("t4_empty", 32'(m_axis_tvalid), 32'd0);
      chk("t4_busy",  32'(busy), 32'd0);
`ifdef ADC_PKT_STALL_CNT_EN
      chk("t4_stall", 32'(stall_count), 32'd4);
`endif

      // Reset with 5 beats buffered
      pkt_len       = 16'd4;
      enable        = 1'b1;
      m_axis_tready = 1'b0;
      cyc();
      chk("t5_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 5; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = 32'(500 + i);
         cyc();
         s_axis_tvalid = 1'b0;
      end
      chk("t5_buf_vld",  32'(m_axis_tvalid), 32'd1);
      chk("t5_buf_data", m_axis_tdata, 32'd500);
      #2;
      ARESETN = 1'b0;
      #1;
      chk("t5_rst_vld",   32'(m_axis_tvalid), 32'd0);
      chk("t5_rst_data",  m_axis_tdata,       32'd0);
      chk("t5_rst_last",  32'(m_axis_tlast),  32'd0);
      chk("t5_rst_rdy",   32'(s_axis_tready), 32'd0);
      chk("t5_rst_busy",  32'(busy),          32'd0);
      chk("t5_rst_count", pkt_count,          32'd0);
      repeat (2) cyc();
      ARESETN       = 1'b1;
      m_axis_tready = 1'b1;
      cyc();
      chk("t5_sync_e1", 32'(busy), 32'd0);
      wait_busy("t5_restart");
      for (int i = 0; i < 4; i++) push_beat(32'(600 + i), i == 3, "t5");
      cyc();
      chk("t5_pkt_count", pkt_count, 32'd1);
      chk("t5_empty", 32'(m_axis_tvalid), 32'd0);
`ifdef ADC_PKT_STALL_CNT_EN
      chk("t5_stall", 32'(stall_count), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/adc_axis_packetizer.md
# adc_axis_packetizer

- Downstream stage of the ADC-to-AXI-Stream converter.
- Accepts its continuous 32-bit sample stream and buffers it in an internal FIFO.
- Cuts the stream into fixed-length packets by generating TLAST every `pkt_len` beats.
- Presents the packets on an AXI4-Stream master suitable for the AXI DMA S2MM channel.

## Interface

Parameters:

- `DATA_WIDTH`, 32: sample/TDATA width.
- `FIFO_DEPTH`, 16: FIFO entries; must be a power of two, ≥4.
- `LEN_WIDTH`, 16: width of `pkt_len` and the beat counter.

Ports:

- `ACLK`  in  1  single clock for all logic.
- `ARESETN`  in  1  asynchronous, active-low reset.
- `enable`  in  1  capture enable, applied only at packet boundaries.
- `pkt_len`  in  LEN_WIDTH  beats per packet; sampled at packet start; 0 is treated as 1.
- `s_axis_tdata`  in  DATA_WIDTH  sample from the ADC converter.
- `s_axis_tvalid`  in  1  sample valid.
- `s_axis_tready`  out  1  packetizer can accept.
- `m_axis_tdata`  out  DATA_WIDTH  packet data.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  downstream accept.
- `m_axis_tlast`  out  1  last beat of packet.
- `pkt_count`  out  32  packets completed on the output (wraps).
- `busy`  out  1  high in state ACTIVE.

## Operation

- FSM states:
  - IDLE: beat counter = 0, `s_axis_tready` = 0.
  - ACTIVE: beats are being accepted into the current packet.
- IDLE→ACTIVE: on any cycle with `enable` = 1.
  - `len_q` ← max(`pkt_len`, 1).
  - Beat counter ← 0.
- In ACTIVE:
  - `s_axis_tready` = !fifo_full.
  - Each input handshake pushes {data, last} into the FIFO and increments the counter.
  - last = (counter == `len_q`−1).
- On the push with last = 1:
  - If `enable` = 1: stay ACTIVE, reload `len_q` from `pkt_len`, counter ← 0.
  - Otherwise: go to IDLE.
- Deasserting `enable` mid-packet has no effect until the packet's last beat has been accepted; packets are never truncated.
- Changes to `pkt_len` mid-packet are ignored.
- The FIFO stores DATA_WIDTH+1 bits per entry, with read/write pointers one bit wider than log2(FIFO_DEPTH).
  - full = (MSBs differ, rest equal).
  - empty = pointers equal.
- Output:
  - `m_axis_tvalid` = !fifo_empty.
  - `m_axis_tdata`/`m_axis_tlast` come from the FIFO head entry, read combinationally from the registered array.
  - An output handshake pops the entry.
- Simultaneous push and pop are legal in any non-full state; occupancy is unchanged.
- When full, push is blocked by `s_axis_tready` = 0.
  - A pop in that same cycle does not enable a push until the next cycle.
- `pkt_count` increments on each output handshake with `m_axis_tlast` = 1.

## Timing

- Reset values (asynchronous on `ARESETN` low):
  - State IDLE, `s_axis_tready` = 0, `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0.
  - `pkt_count` = 0, `busy` = 0, FIFO empty, counter = 0.
- Reset mid-packet discards all FIFO contents and the partial packet.
- Reset release is synchronised internally: the FSM leaves IDLE no earlier than the 2nd rising edge after `ARESETN` rises.
- IDLE→ACTIVE takes 1 cycle: `s_axis_tready` rises the cycle after `enable` is seen high.
- Input-to-output latency is 1 cycle: a beat accepted at edge N gives `m_axis_tvalid` = 1 after edge N.
- Throughput is one beat per cycle with `m_axis_tready` held high.
- The output obeys AXI-Stream: once `m_axis_tvalid` is asserted, data, last and valid are held stable until the handshake.

## Configuration

- Macro: `ADC_PKT_STALL_CNT_EN`.
- Defined:
  - Adds output port `stall_count` (16 bits).
  - Counts cycles with `s_axis_tvalid` = 1 and `s_axis_tready` = 0, i.e. samples the ADC converter had to hold.
  - Saturates at 0xFFFF; reset value 0; clears on `ARESETN` only.
- Not defined: the port and counter are absent, and there is no other behavioural change.

## Test plan

- Basic packet: `pkt_len` = 4, `enable` = 1, input 1,2,3,…,8 back-to-back, `m_axis_tready` = 1.
  - Expect two packets with `m_axis_tlast` on beats with data 4 and 8, first output one cycle after the first input, `pkt_count` = 2.
- Backpressure: `m_axis_tready` = 0, 20 inputs offered, FIFO_DEPTH = 16.
  - Expect `s_axis_tready` low after 16 accepts.
  - Then release: 16 beats emerge in order with no loss.
  - With `ADC_PKT_STALL_CNT_EN`, `stall_count` equals the stalled cycles.
- Enable drop mid-packet: `pkt_len` = 8, `enable` falls after beat 3.
  - Expect beats 4..8 still accepted, `tlast` on beat 8, then `s_axis_tready` = 0 and `busy` = 0.
- `pkt_len` = 0 and `pkt_len` changed mid-packet (4→2 after beat 1).
  - With `pkt_len` = 0, every beat carries `tlast`.
  - With the mid-packet change, the current packet still ends at beat 4 and the next packet is 2 beats.
- Reset mid-packet: assert `ARESETN` low with 5 entries buffered.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, a fresh 4-beat packet is produced with `pkt_count` = 1.
